npu_inst_fetch: RTL and testbench

Instruction fetch sequencer for the NPU. It owns the second port of the 256 x 128-bit instruction SRAM and fetches a contiguous instruction range, start to end address, into a small prefetch FIFO. It presents the instructions to the NPU decoder over a valid/ready handshake. The first port stays with the HPS loader; this block never writes the SRAM.

---
 rtl/npu_inst_fetch.sv | 169 ++++++++++++++++
 tb/tb_npu_inst_fetch.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_inst_fetch.sv
// Instruction fetch sequencer: reads a contiguous SRAM range into a prefetch FIFO for the decoder.
// Optional build macro IFETCH_PERF_CNT_EN enables the stall/instruction performance counters.
module npu_inst_fetch #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 128,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    input  logic [ADDR_W-1:0] end_pc,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] sram_address,
    output logic              sram_chipselect,
    output logic              sram_write,
    output logic              sram_clken,
    input  logic [DATA_W-1:0] sram_readdata,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       perf_stall_cycles,
    output logic [31:0]       perf_instr_count,
    output logic [1:0]        dbg_state
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;
    state_t state, state_nxt;

    logic [ADDR_W-1:0] pc, last, pend_pc;
    logic              pending;
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              busy_nxt, done_nxt;
    logic              accept_start, flush_act, can_issue, issue, push, pop, drain_empty;

    // Handshake: a word transfers on every clock edge where instr_valid and instr_ready are both
    // high; instr_valid only drops without a transfer when a flush discards the FIFO.
    assign accept_start = (state == S_IDLE) && start;
    assign flush_act    = flush && (state != S_IDLE);
    // Issue check counts the in-flight read and ignores a same-cycle pop.
    assign can_issue    = (state == S_FETCH) && ((count + CNT_W'(pending)) < DEPTH_C);
    assign issue        = can_issue && !flush_act;
    assign push         = pending && !flush_act;
    assign pop          = instr_valid && instr_ready && !flush_act;
    assign drain_empty  = !pending && ((count == '0) || ((count == CNT_W'(1)) && pop));

    assign sram_address    = pc;
    assign sram_chipselect = can_issue;
    assign sram_write      = 1'b0;
    assign sram_clken      = 1'b1;
    assign instr_valid     = (count != '0);
    assign instr_data      = fifo_data[rd_ptr];
    assign instr_pc        = fifo_pc[rd_ptr];
    assign dbg_state       = state;

    always_comb begin
        state_nxt = state;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_FETCH;
                    busy_nxt  = 1'b1;
                end
            end
            S_FETCH: begin
                if (issue && (pc == last)) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (flush) begin
                    state_nxt = S_FETCH;
                end else if (drain_empty) begin
                    state_nxt = S_IDLE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc      <= '0;
            last    <= '0;
            pend_pc <= '0;
            pending <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_pc[i]   <= '0;
            end
        end else begin
            if (accept_start) begin
                pc   <= start_pc;
                last <= end_pc;
            end else if (flush_act) begin
                pc <= flush_pc;
            end else if (issue) begin
                pc <= pc + ADDR_W'(1);
            end
            pending <= issue;
            if (issue) pend_pc <= pc;

            if (flush_act) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    fifo_data[wr_ptr] <= sram_readdata;
                    fifo_pc[wr_ptr]   <= pend_pc;
                    wr_ptr            <= wr_ptr + PTR_W'(1);
                end
                if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] stall_q, instr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
            instr_q <= '0;
        end else if (accept_start) begin
            stall_q <= '0;
            instr_q <= '0;
        end else begin
            if (busy && !instr_valid && (stall_q != '1)) stall_q <= stall_q + 32'd1;
            if (pop && (instr_q != '1)) instr_q <= instr_q + 32'd1;
        end
    end

    assign perf_stall_cycles = stall_q;
    assign perf_instr_count  = instr_q;
`else
    assign perf_stall_cycles = '0;
    assign perf_instr_count  = '0;
`endif

endmodule

// File: tb/tb_npu_inst_fetch.sv
// Bench for npu_inst_fetch: table-driven runs, directed corner sequences and randomized runs
// checked against a queue of expected fetch addresses.
module tb_npu_inst_fetch;
    localparam int W  = 8;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  start_pc = '0;
    logic [W-1:0]  end_pc = '0;
    logic          flush = 1'b0;
    logic [W-1:0]  flush_pc = '0;
    logic          instr_ready = 1'b0;
    logic [DW-1:0] sram_readdata = '0;
    logic          busy, done, sram_chipselect, sram_write, sram_clken, instr_valid;
    logic [W-1:0]  sram_address, instr_pc;
    logic [DW-1:0] instr_data;
    logic [31:0]   perf_stall_cycles, perf_instr_count;
    logic [1:0]    dbg_state;

    int errors = 0;
    int checks = 0;
    int delivered = 0;
    int issued = 0;
    logic [W-1:0]  exp_q[$];
    logic [DW-1:0] sram_mem[256];

    typedef struct {
        logic [W-1:0] s;
        logic [W-1:0] e;
        int           mode;
        int           n_exp;
    } vec_t;
    vec_t vecs[7];

    npu_inst_fetch dut (
        .clk(clk), .reset_n(reset_n), .start(start), .start_pc(start_pc), .end_pc(end_pc),
        .flush(flush), .flush_pc(flush_pc), .busy(busy), .done(done),
        .sram_address(sram_address), .sram_chipselect(sram_chipselect),
        .sram_write(sram_write), .sram_clken(sram_clken), .sram_readdata(sram_readdata),
        .instr_data(instr_data), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .perf_stall_cycles(perf_stall_cycles),
        .perf_instr_count(perf_instr_count), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL global_timeout: simulation still running, want finished");
        $fatal(1);
    end

    // synchronous-read SRAM port model
    always @(posedge clk) begin
        if (sram_chipselect) sram_readdata <= sram_mem[sram_address];
    end

    function automatic logic [DW-1:0] word_of(input logic [W-1:0] a);
        return {32'hC0DE_0000 | {24'h0, a}, {4{a}}, ~{4{a}}, 24'h5A5A5A, a};
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // scoreboard: every accepted instruction must be the next expected address and its word
    always @(negedge clk) begin : mon
        logic [W-1:0] e;
        if (reset_n && sram_chipselect && !flush) issued++;
        if (reset_n && instr_valid && instr_ready && !flush) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_instr: got pc %0d, want no instruction", instr_pc);
            end else begin
                e = exp_q.pop_front();
                chk("instr_pc", DW'(instr_pc), DW'(e));
                chk("instr_data", instr_data, word_of(e));
                delivered++;
            end
        end
    end

    // reference model: the run yields every address from s up to e inclusive, mod 256
    task automatic model_fill(input logic [W-1:0] s, input logic [W-1:0] e);
        int n;
        exp_q.delete();
        n = int'(W'(e - s)) + 1;
        for (int i = 0; i < n; i++) exp_q.push_back(W'(s + W'(i)));
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [W-1:0] s, input logic [W-1:0] e);
        start_pc = s;
        end_pc   = e;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    task automatic wait_done(input int n_exp, input int rand_mode, input string name,
                             input logic [W-1:0] last_m);
        bit seen = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            step();
            flush = 1'b0;
            if (rand_mode >= 1) instr_ready = ($urandom_range(0, 3) != 0);
            if (rand_mode == 2 && busy && $urandom_range(0, 24) == 0) begin
                flush    = 1'b1;
                flush_pc = last_m - W'($urandom_range(0, 12));
                model_fill(flush_pc, last_m);
            end
        end
        flush = 1'b0;
        chk({name, "_done_seen"}, DW'(seen), DW'(1));
        if (n_exp >= 0) chk({name, "_count"}, DW'(delivered), DW'(n_exp));
        chk({name, "_exp_empty"}, DW'(exp_q.size()), DW'(0));
        chk({name, "_busy_low"}, DW'(busy), DW'(0));
        step();
        @(negedge clk);
        chk({name, "_done_pulse"}, DW'(done), DW'(0));
    endtask

    task automatic run(input logic [W-1:0] s, input logic [W-1:0] e, input int mode,
                       input int n_exp, input string name);
        model_fill(s, e);
        delivered = 0;
        do_start(s, e);
        wait_done(n_exp, mode, name, e);
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, "_busy"}, DW'(busy), DW'(0));
        chk({name, "_done"}, DW'(done), DW'(0));
        chk({name, "_cs"}, DW'(sram_chipselect), DW'(0));
        chk({name, "_valid"}, DW'(instr_valid), DW'(0));
        chk({name, "_addr"}, DW'(sram_address), DW'(0));
        chk({name, "_ipc"}, DW'(instr_pc), DW'(0));
        chk({name, "_idata"}, instr_data, DW'(0));
        chk({name, "_perf_stall"}, DW'(perf_stall_cycles), DW'(0));
        chk({name, "_perf_instr"}, DW'(perf_instr_count), DW'(0));
    endtask

    initial begin
        bit found;
        logic [W-1:0] rs, re;
        for (int i = 0; i < 256; i++) sram_mem[i] = word_of(W'(i));
        vecs[0] = '{8'd4,   8'd7,   0, 4};
        vecs[1] = '{8'd254, 8'd1,   0, 4};
        vecs[2] = '{8'd3,   8'd3,   0, 1};
        vecs[3] = '{8'd0,   8'd9,   1, 10};
        vecs[4] = '{8'd250, 8'd5,   1, 12};
        vecs[5] = '{8'd100, 8'd99,  0, 256};
        vecs[6] = '{8'd200, 8'd200, 1, 1};

        // reset state
        repeat (3) step();
        @(negedge clk);
        check_idle_outputs("reset");
        chk("sram_write", DW'(sram_write), DW'(0));
        chk("sram_clken", DW'(sram_clken), DW'(1));
        step();
        reset_n = 1'b1;
        step();

        // basic run 4..7: two-cycle latency, one word per cycle, done after last pop
        instr_ready = 1'b1;
        model_fill(8'd4, 8'd7);
        delivered = 0;
        do_start(8'd4, 8'd7);
        @(negedge clk);
        chk("basic_busy", DW'(busy), DW'(1));
        chk("basic_lat0", DW'(instr_valid), DW'(0));
        step();
        @(negedge clk);
        chk("basic_lat1", DW'(instr_valid), DW'(0));
        for (int k = 0; k < 4; k++) begin
            step();
            @(negedge clk);
            chk("basic_valid", DW'(instr_valid), DW'(1));
            chk("basic_pc", DW'(instr_pc), DW'(4 + k));
            chk("basic_no_done", DW'(done), DW'(0));
        end
        step();
        @(negedge clk);
        chk("basic_done", DW'(done), DW'(1));
        chk("basic_busy_fall", DW'(busy), DW'(0));
        chk("basic_empty", DW'(instr_valid), DW'(0));
        step();
        @(negedge clk);
        chk("basic_done_pulse", DW'(done), DW'(0));
        chk("basic_count", DW'(delivered), DW'(4));
`ifdef IFETCH_PERF_CNT_EN
        chk("perf_instr", DW'(perf_instr_count), DW'(4));
        chk("perf_stall", DW'(perf_stall_cycles), DW'(2));
`else
        chk("perf_instr", DW'(perf_instr_count), DW'(0));
        chk("perf_stall", DW'(perf_stall_cycles), DW'(0));
`endif
        step();

        // backpressure: only FIFO_DEPTH reads while the decoder stalls
        instr_ready = 1'b0;
        model_fill(8'd0, 8'd9);
        delivered = 0;
        issued = 0;
        do_start(8'd0, 8'd9);
        repeat (10) step();
        @(negedge clk);
        chk("bp_issued", DW'(issued), DW'(4));
        chk("bp_valid", DW'(instr_valid), DW'(1));
        chk("bp_head", DW'(instr_pc), DW'(0));
        chk("bp_cs_off", DW'(sram_chipselect), DW'(0));
        step();
        instr_ready = 1'b1;
        wait_done(10, 0, "bp", 8'd9);

        // table-driven runs
        foreach (vecs[i]) begin
            instr_ready = 1'b1;
            run(vecs[i].s, vecs[i].e, vecs[i].mode, vecs[i].n_exp, $sformatf("vec%0d", i));
        end

        // flush at head pc 5 to 15 within run 0..20
        instr_ready = 1'b1;
        model_fill(8'd0, 8'd20);
        delivered = 0;
        do_start(8'd0, 8'd20);
        found = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (instr_valid && instr_pc == 8'd5) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("flush_head_found", DW'(found), DW'(1));
        flush    = 1'b1;
        flush_pc = 8'd15;
        model_fill(8'd15, 8'd20);
        delivered = 0;
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_lat0", DW'(instr_valid), DW'(0));
        step();
        @(negedge clk);
        chk("flush_lat1", DW'(instr_valid), DW'(0));
        step();
        @(negedge clk);
        chk("flush_valid", DW'(instr_valid), DW'(1));
        chk("flush_pc", DW'(instr_pc), DW'(15));
        wait_done(6, 0, "flush", 8'd20);

        // reset mid-run aborts without done
        instr_ready = 1'b1;
        model_fill(8'd0, 8'd20);
        do_start(8'd0, 8'd20);
        repeat (5) step();
        reset_n = 1'b0;
        @(negedge clk);
        check_idle_outputs("midreset");
        for (int k = 0; k < 3; k++) begin
            step();
            @(negedge clk);
            chk("midreset_no_done", DW'(done), DW'(0));
        end
        step();
        reset_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("postreset_no_done", DW'(done), DW'(0));
        chk("postreset_busy", DW'(busy), DW'(0));
        step();
        run(8'd3, 8'd3, 0, 1, "single");

        // randomized runs with random backpressure and flushes
        for (int r = 0; r < 12; r++) begin
            rs = W'($urandom_range(0, 255));
            re = rs + W'($urandom_range(0, 30));
            instr_ready = 1'b1;
            run(rs, re, 2, -1, $sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
